hex_scan_display: RTL and testbench
===================================

# hex_scan_display

Parametrised multi-digit hexadecimal display driver for the board's seven-segment bank. It holds a loadable NUM_DIGITS-nibble value and drives two outputs from it. One is a static per-digit segment bus for boards with dedicated segment pins. The other is a time-multiplexed segment/anode pair for boards with shared segment lines. Both outputs support leading-zero blanking and per-digit blinking. Game logic (score, move counter, level) instantiates it in place of a bank of per-digit combinational decoders.

## Interface
- NUM_DIGITS, 4, number of hex digits displayed (1..8)
- SCAN_DIV, 50000, clocks each digit is held on the scanned output (>=1)
- BLINK_TICKS, 256, scan ticks per blink half-period (>=1)
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- value  in  4*NUM_DIGITS  display value; digit i = value[4i+3:4i]; digit 0 is least significant
- load  in  1  capture value into the display register this cycle
- lz_en  in  1  leading-zero blanking enable
- blink_mask  in  NUM_DIGITS  bit i set: digit i blinks
- seg_all  out  7*NUM_DIGITS  static segments; digit i on [7i+6:7i], active-low, bit order gfedcba
- scan_seg  out  7  multiplexed segments, active-low, gfedcba
- scan_an  out  NUM_DIGITS  digit enables, active-low, exactly one low after first tick

## Operation
- Segment encoding is active-low, with bit 6 = g and bit 0 = a.
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:18 A:08 b:03 C:46 d:21 E:06 F:0E (hex).
  - Blank is 7F.
- Display register val_q:
  - reset clears it to 0.
  - load=1 captures value; otherwise it holds.
- Digit blanking: digit i is blank (7F) when either condition holds:
  - Leading zero: lz_en=1, i>0, and digits i..NUM_DIGITS-1 of val_q are all 0. Digit 0 is never blanked by leading-zero logic, so a value of 0 shows a single "0".
  - Blink: blink_mask[i]=1 and blink phase ph=1.
- Blink phase ph:
  - toggles each time the blink counter reaches BLINK_TICKS-1 on a scan tick, and the counter wraps to 0.
  - reset sets ph=0 and clears the counter.
- Scan prescaler pc:
  - counts 0..SCAN_DIV-1; wrapping from SCAN_DIV-1 to 0 produces a one-cycle scan tick.
  - With SCAN_DIV=1, every cycle is a tick.
- Digit index idx:
  - advances on each tick and wraps from NUM_DIGITS-1 to 0.
  - load never disturbs idx, pc or the blink counter.
- seg_all is registered and updated every cycle from the current val_q, lz_en, blink_mask and ph.
- scan_seg and scan_an are registered and updated every cycle from idx:
  - scan_seg = digit idx after blanking.
  - scan_an has only bit idx low.
- Reset state: val_q=0, pc=0, idx=0, ph=0, blink counter 0.
- Reset value of all outputs:
  - seg_all all 1s (blank).
  - scan_seg = 7F.
  - scan_an all 1s (all digits off).
- The outputs leave the reset pattern on the first edge after reset deasserts.

## Timing
- Load latency:
  - load sampled at edge N sets val_q at N.
  - seg_all and scan_seg reflect the new value at edge N+1, one cycle after load.
- lz_en and blink_mask are used combinationally into the output registers, so each change is visible 1 cycle later.
- Scan timing:
  - The first tick after reset occurs SCAN_DIV cycles after reset deasserts.
  - idx changes on the tick edge; scan_an/scan_seg follow one edge later.
  - Each digit is displayed for exactly SCAN_DIV cycles.
- Blink timing: ph toggles every SCAN_DIV*BLINK_TICKS cycles.
- Simultaneous events:
  - load on a tick cycle: idx advances and the next scan output uses the new val_q.
  - reset dominates load and ticks in the same cycle.
  - Reset asserted mid-scan returns every output to its reset value on that edge.
- No glitch: scan_seg and scan_an change on the same edge.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, BLINK_TICKS=2.
- **Reset:** hold reset 3 cycles, then release -> seg_all=0x0FFFFFFF (all 1s), scan_seg=7F, scan_an=F during reset. One cycle after release, seg_all digits all 40 (value 0, lz_en=0).
- **Load/decode:** load value=16'hA5C3, lz_en=0 -> one cycle later seg_all = d3:08 d2:12 d1:46 d0:30. Verify all 16 codes via four loads.
- **Scan:** hold value=16'h1234 -> scan_an sequence E,D,B,7,E repeating, each held 4 cycles; scan_seg 19,30,24,79 in step.
- **Leading zero:** lz_en=1.
  - value=16'h0050 -> digits 3,2 blank (7F), d1=12, d0=40.
  - value=0 -> only d0=40.
  - value=16'h0100 -> d2=79, d1=40, d0=40.
- **Blink:** blink_mask=4'b0010, value=16'h8888 -> d1 alternates 00 and 7F every 8 cycles while the other digits stay 00.
- **Mid-operation events:**
  - load on a tick edge -> new value on the next scan output, idx sequence unbroken.
  - reset during digit 2 -> scan_an=F next edge, scan restarts at digit 0 after SCAN_DIV cycles.

Source files
------------

// File: rtl/hex_scan_display.sv
// hex_scan_display: loadable multi-digit hex value shown on a seven-segment bank.
// Provides a static per-digit segment bus and a time-multiplexed segment/anode
// pair, both with leading-zero blanking and per-digit blinking. Segments are
// active-low in gfedcba order (bit 6 = g, bit 0 = a).
module hex_scan_display #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned BLINK_TICKS = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    lz_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7*NUM_DIGITS-1:0] seg_all,
    output logic [6:0]              scan_seg,
    output logic [NUM_DIGITS-1:0]   scan_an
);

    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned SEG_W = 7 * NUM_DIGITS;
    localparam int unsigned PC_W  = (SCAN_DIV > 1)    ? $clog2(SCAN_DIV)    : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;
    localparam int unsigned BC_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [6:0]       SEG_BLANK = 7'h7F;
    localparam logic [PC_W-1:0]  PC_LAST   = PC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BC_W-1:0]  BC_LAST   = BC_W'(BLINK_TICKS - 1);

    // Hex nibble to active-low gfedcba pattern
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h18;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [VAL_W-1:0] val_q;
    logic [PC_W-1:0]  pc_q;
    logic [IDX_W-1:0] idx_q;
    logic [BC_W-1:0]  bc_q;
    logic             ph_q;

    logic             tick_c;
    logic [6:0]       digit_seg_c [NUM_DIGITS];
    logic [SEG_W-1:0] seg_all_c;

    // Display register: captures the value on load, otherwise holds
    always_ff @(posedge clk) begin
        if (reset) begin
            val_q <= '0;
        end else if (load) begin
            val_q <= value;
        end
    end

    // Scan tick: prescaler about to wrap
    always_comb begin
        tick_c = (pc_q == PC_LAST);
    end

    // Scan prescaler, digit index and blink phase; load never touches these
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= '0;
            idx_q <= '0;
            bc_q  <= '0;
            ph_q  <= 1'b0;
        end else if (tick_c) begin
            pc_q  <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            if (bc_q == BC_LAST) begin
                bc_q <= '0;
                ph_q <= ~ph_q;
            end else begin
                bc_q <= bc_q + 1'b1;
            end
        end else begin
            pc_q <= pc_q + 1'b1;
        end
    end

    // Per-digit decode with leading-zero and blink blanking; digit 0 always shows
    always_comb begin
        logic [3:0] nib;
        logic       zero_above;
        logic       lz_blank;
        logic       bl_blank;
        nib        = 4'h0;
        zero_above = 1'b1;
        lz_blank   = 1'b0;
        bl_blank   = 1'b0;
        seg_all_c  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_seg_c[i] = SEG_BLANK;
        end
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib        = val_q[4*i +: 4];
            zero_above = zero_above & (nib == 4'h0);
            lz_blank   = lz_en & (i != 0) & zero_above;
            bl_blank   = blink_mask[i] & ph_q;
            digit_seg_c[i]      = (lz_blank | bl_blank) ? SEG_BLANK : hex_to_seg(nib);
            seg_all_c[7*i +: 7] = digit_seg_c[i];
        end
    end

    // Registered outputs; scan_seg and scan_an update on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_all  <= '1;
            scan_seg <= SEG_BLANK;
            scan_an  <= '1;
        end else begin
            seg_all  <= seg_all_c;
            scan_seg <= digit_seg_c[idx_q];
            scan_an  <= ~(NUM_DIGITS'(1) << idx_q);
        end
    end

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench for hex_scan_display: expectations are pushed as each cycle
// is driven and popped/compared once the corresponding output edge has passed.
module tb_hex_scan_display;

    localparam int unsigned ND = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned BT = 2;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic        lz_en;
    logic [3:0]  blink_mask;
    logic [27:0] seg_all;
    logic [6:0]  scan_seg;
    logic [3:0]  scan_an;

    hex_scan_display #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .BLINK_TICKS(BT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .load      (load),
        .lz_en     (lz_en),
        .blink_mask(blink_mask),
        .seg_all   (seg_all),
        .scan_seg  (scan_seg),
        .scan_an   (scan_an)
    );

    typedef struct packed {
        logic [27:0] sa;
        logic [6:0]  ss;
        logic [3:0]  an;
    } exp_t;

    exp_t        exp_q[$];
    int          total;
    int          bad;
    int          e;
    logic [15:0] vq;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference segment table
    function automatic logic [6:0] seg_lut(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h18; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    // Expected static bus for a value, blanking controls and blink phase
    function automatic logic [27:0] model_seg_all(input logic [15:0] v, input logic lz,
                                                  input logic [3:0] m, input logic p);
        logic [27:0] r;
        logic [3:0]  nib;
        logic        upper_zero;
        r = '1;
        upper_zero = 1'b1;
        for (int i = ND - 1; i >= 0; i--) begin
            nib = v[4*i +: 4];
            upper_zero = upper_zero && (nib == 4'h0);
            if ((lz && i > 0 && upper_zero) || (m[i] && p)) r[7*i +: 7] = 7'h7F;
            else r[7*i +: 7] = seg_lut(nib);
        end
        return r;
    endfunction

    // Push the expectation for the coming edge, then advance to the sample point
    task automatic step();
        exp_t x;
        int   d;
        logic p;
        if (reset) begin
            x.sa = '1;
            x.ss = 7'h7F;
            x.an = 4'hF;
            e    = 0;
            vq   = 16'h0;
        end else begin
            e    = e + 1;
            d    = ((e - 1) / SD) % ND;
            p    = ((((e - 1) / (SD * BT)) % 2) == 1);
            x.sa = model_seg_all(vq, lz_en, blink_mask, p);
            x.ss = x.sa[7*d +: 7];
            x.an = 4'hF ^ (4'h1 << d);
            if (load) vq = value;
        end
        exp_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t x;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            x = exp_q.pop_front();
            total++;
            if ({seg_all, scan_seg, scan_an} !== x) begin
                bad++;
                $display("FAIL reset cyc=%0d got sa=%h ss=%h an=%h want sa=%h ss=%h an=%h",
                         k, seg_all, scan_seg, scan_an, x.sa, x.ss, x.an);
            end
        end
        reset = 1'b0;
        step();
        x = exp_q.pop_front();
        total++;
        if ({seg_all, scan_seg, scan_an} !== x) begin
            bad++;
            $display("FAIL reset_release got sa=%h ss=%h an=%h want sa=%h ss=%h an=%h",
                     seg_all, scan_seg, scan_an, x.sa, x.ss, x.an);
        end
        total++;
        if (seg_all !== {4{7'h40}}) begin
            bad++;
            $display("FAIL reset_zero got sa=%h want %h", seg_all, {4{7'h40}});
        end
    endtask

    task automatic test_load_decode();
        exp_t        x;
        logic [15:0] vals [5] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC, 16'hA5C3};
        lz_en = 1'b0;
        blink_mask = 4'h0;
        for (int j = 0; j < 5; j++) begin
            value = vals[j];
            for (int k = 0; k < 2; k++) begin
                load = (k == 0);
                step();
                x = exp_q.pop_front();
                total++;
                if ({seg_all, scan_seg, scan_an} !== x) begin
                    bad++;
                    $display("FAIL decode v=%h k=%0d got sa=%h ss=%h an=%h want sa=%h ss=%h an=%h",
                             vals[j], k, seg_all, scan_seg, scan_an, x.sa, x.ss, x.an);
                end
            end
        end
        load = 1'b0;
        total++;
        if (seg_all !== {7'h08, 7'h12, 7'h46, 7'h30}) begin
            bad++;
            $display("FAIL decode_a5c3 got sa=%h want %h", seg_all, {7'h08, 7'h12, 7'h46, 7'h30});
        end
    endtask

    task automatic test_scan();
        exp_t x;
        value = 16'h1234;
        load  = 1'b1;
        for (int k = 0; k < 22; k++) begin
            step();
            load = 1'b0;
            x = exp_q.pop_front();
            total++;
            if ({seg_all, scan_seg, scan_an} !== x) begin
                bad++;
                $display("FAIL scan e=%0d got sa=%h ss=%h an=%h want sa=%h ss=%h an=%h",
                         e, seg_all, scan_seg, scan_an, x.sa, x.ss, x.an);
            end
        end
    endtask

    task automatic test_leading_zero();
        exp_t        x;
        logic [15:0] vals [3] = '{16'h0050, 16'h0000, 16'h0100};
        logic [27:0] want [3] = '{{7'h7F, 7'h7F, 7'h12, 7'h40},
                                  {7'h7F, 7'h7F, 7'h7F, 7'h40},
                                  {7'h7F, 7'h79, 7'h40, 7'h40}};
        lz_en = 1'b1;
        for (int j = 0; j < 3; j++) begin
            value = vals[j];
            for (int k = 0; k < 2; k++) begin
                load = (k == 0);
                step();
                x = exp_q.pop_front();
                total++;
                if ({seg_all, scan_seg, scan_an} !== x) begin
                    bad++;
                    $display("FAIL lz v=%h k=%0d got sa=%h ss=%h an=%h want sa=%h ss=%h an=%h",
                             vals[j], k, seg_all, scan_seg, scan_an, x.sa, x.ss, x.an);
                end
            end
            load = 1'b0;
            total++;
            if (seg_all !== want[j]) begin
                bad++;
                $display("FAIL lz_literal v=%h got sa=%h want %h", vals[j], seg_all, want[j]);
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_blink();
        exp_t x;
        value = 16'h8888;
        blink_mask = 4'b0010;
        load = 1'b1;
        for (int k = 0; k < 26; k++) begin
            step();
            load = 1'b0;
            x = exp_q.pop_front();
            total++;
            if ({seg_all, scan_seg, scan_an} !== x) begin
                bad++;
                $display("FAIL blink e=%0d got sa=%h ss=%h an=%h want sa=%h ss=%h an=%h",
                         e, seg_all, scan_seg, scan_an, x.sa, x.ss, x.an);
            end
        end
        blink_mask = 4'h0;
    endtask

    task automatic test_load_on_tick();
        exp_t x;
        int   guard;
        guard = 0;
        while (((e + 1) % SD) != 0 && guard < 8) begin
            guard++;
            step();
            x = exp_q.pop_front();
            total++;
            if ({seg_all, scan_seg, scan_an} !== x) begin
                bad++;
                $display("FAIL tick_align e=%0d got sa=%h ss=%h an=%h want sa=%h ss=%h an=%h",
                         e, seg_all, scan_seg, scan_an, x.sa, x.ss, x.an);
            end
        end
        value = 16'hBEEF;
        load  = 1'b1;
        for (int k = 0; k < 14; k++) begin
            step();
            load = 1'b0;
            x = exp_q.pop_front();
            total++;
            if ({seg_all, scan_seg, scan_an} !== x) begin
                bad++;
                $display("FAIL load_tick e=%0d got sa=%h ss=%h an=%h want sa=%h ss=%h an=%h",
                         e, seg_all, scan_seg, scan_an, x.sa, x.ss, x.an);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t x;
        int   guard;
        guard = 0;
        value = 16'h4321;
        load  = 1'b1;
        while ((((e / SD) % ND) != 2 || load) && guard < 20) begin
            guard++;
            step();
            load = 1'b0;
            x = exp_q.pop_front();
            total++;
            if ({seg_all, scan_seg, scan_an} !== x) begin
                bad++;
                $display("FAIL pre_reset e=%0d got sa=%h ss=%h an=%h want sa=%h ss=%h an=%h",
                         e, seg_all, scan_seg, scan_an, x.sa, x.ss, x.an);
            end
        end
        reset = 1'b1;
        load  = 1'b1;
        value = 16'h9999;
        for (int k = 0; k < 14; k++) begin
            step();
            reset = 1'b0;
            load  = 1'b0;
            x = exp_q.pop_front();
            total++;
            if ({seg_all, scan_seg, scan_an} !== x) begin
                bad++;
                $display("FAIL reset_mid k=%0d got sa=%h ss=%h an=%h want sa=%h ss=%h an=%h",
                         k, seg_all, scan_seg, scan_an, x.sa, x.ss, x.an);
            end
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        e          = 0;
        vq         = 16'h0;
        reset      = 1'b1;
        load       = 1'b0;
        value      = 16'h0;
        lz_en      = 1'b0;
        blink_mask = 4'h0;

        test_reset();
        test_load_decode();
        test_scan();
        test_leading_zero();
        test_blink();
        test_load_on_tick();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
